// File: rtl/sonar_tx_pkg.sv
// rtl/sonar_tx_pkg.sv - shared types and constants for the sonar burst transmitter
package sonar_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        BLANK = 2'd2,
        FIN   = 2'd3
    } tx_state_e;

    localparam int CNT_W_DEF       = 16;
    localparam int NP_W_DEF        = 8;
    localparam int MIN_HALF_PERIOD = 1;

endpackage

// File: rtl/sonar_tx_timer.sv
// rtl/sonar_tx_timer.sv - loadable down-counter with registered zero flag
module sonar_tx_timer
    import sonar_tx_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    // load has priority over enable; the count saturates at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            zero  <= 1'b1;
        end else if (load) begin
            count <= load_val;
            zero  <= (load_val == '0);
        end else if (en && (count != '0)) begin
            count <= count - CNT_W'(1);
            zero  <= (count == CNT_W'(1));
        end
    end

endmodule

// File: rtl/sonar_burst_tx.sv
// rtl/sonar_burst_tx.sv - ultrasonic burst generator with blanking; optional SONAR_TX_DEADTIME_EN
module sonar_burst_tx
    import sonar_tx_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int NP_W  = NP_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] half_period,
    input  logic [NP_W-1:0]  num_cycles,
    input  logic [CNT_W-1:0] blank_len,
`ifdef SONAR_TX_DEADTIME_EN
    input  logic [7:0]       dead_time,
`endif
    output logic             tx_p,
    output logic             tx_n,
    output logic             rx_blank,
    output logic             busy,
    output logic             done
);

    tx_state_e        state, state_n;
    logic             phase, phase_n;          // 0 = high half, 1 = low half
    logic [NP_W-1:0]  cyc_left, cyc_left_n;    // full cycles remaining incl. current
    logic [CNT_W-1:0] hp_r, hp_n, bl_r, bl_n;
    logic [CNT_W-1:0] hp_in, hpm1_in;
    logic             ht_load, ht_en, ht_zero;
    logic             bt_load, bt_en, bt_zero;
    logic [CNT_W-1:0] ht_val, bt_val;
    logic             drive_ok_n;

    assign hp_in   = (half_period < CNT_W'(MIN_HALF_PERIOD)) ? CNT_W'(MIN_HALF_PERIOD) : half_period;
    assign hpm1_in = hp_in - CNT_W'(1);

`ifdef SONAR_TX_DEADTIME_EN
    logic [7:0] dt_r, dt_n, dead_r, dead_n, dt_in;
    logic [CNT_W-1:0] dt_wide;

    assign dt_wide = CNT_W'(dead_time);
    assign dt_in   = (dt_wide > hpm1_in) ? hpm1_in[7:0] : dead_time;
`endif

    sonar_tx_timer #(.CNT_W(CNT_W)) u_half_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (ht_load),
        .en       (ht_en),
        .load_val (ht_val),
        .zero     (ht_zero)
    );

    sonar_tx_timer #(.CNT_W(CNT_W)) u_blank_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (bt_load),
        .en       (bt_en),
        .load_val (bt_val),
        .zero     (bt_zero)
    );

    // state and latched configuration registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            phase    <= 1'b0;
            cyc_left <= '0;
            hp_r     <= '0;
            bl_r     <= '0;
`ifdef SONAR_TX_DEADTIME_EN
            dt_r     <= '0;
            dead_r   <= '0;
`endif
        end else begin
            state    <= state_n;
            phase    <= phase_n;
            cyc_left <= cyc_left_n;
            hp_r     <= hp_n;
            bl_r     <= bl_n;
`ifdef SONAR_TX_DEADTIME_EN
            dt_r     <= dt_n;
            dead_r   <= dead_n;
`endif
        end
    end

    // next-state, timer control and dead-time window for the coming cycle
    always_comb begin
        state_n    = state;
        phase_n    = phase;
        cyc_left_n = cyc_left;
        hp_n       = hp_r;
        bl_n       = bl_r;
        ht_load    = 1'b0;
        ht_en      = 1'b0;
        ht_val     = hp_r - CNT_W'(1);
        bt_load    = 1'b0;
        bt_en      = 1'b0;
        bt_val     = bl_r - CNT_W'(1);

        case (state)
            IDLE: begin
                if (start) begin
                    hp_n       = hp_in;
                    bl_n       = blank_len;
                    cyc_left_n = num_cycles;
                    phase_n    = 1'b0;
                    if (num_cycles != '0) begin
                        state_n = BURST;
                        ht_load = 1'b1;
                        ht_val  = hpm1_in;
                    end else if (blank_len != '0) begin
                        state_n = BLANK;
                        bt_load = 1'b1;
                        bt_val  = blank_len - CNT_W'(1);
                    end else begin
                        state_n = FIN;
                    end
                end
            end
            BURST: begin
                if (!ht_zero) begin
                    ht_en = 1'b1;
                end else if (!phase) begin
                    phase_n = 1'b1;
                    ht_load = 1'b1;
                end else if (cyc_left != NP_W'(1)) begin
                    cyc_left_n = cyc_left - NP_W'(1);
                    phase_n    = 1'b0;
                    ht_load    = 1'b1;
                end else if (bl_r != '0) begin
                    state_n = BLANK;
                    bt_load = 1'b1;
                end else begin
                    state_n = FIN;
                end
            end
            BLANK: begin
                if (bt_zero) state_n = FIN;
                else         bt_en   = 1'b1;
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // abort only matters once a burst is under way; in IDLE start wins
        if ((state != IDLE) && abort) begin
            state_n = IDLE;
            ht_load = 1'b0;
            ht_en   = 1'b0;
            bt_load = 1'b0;
            bt_en   = 1'b0;
        end

`ifdef SONAR_TX_DEADTIME_EN
        // every half-timer reload opens a new half, which starts with dt dead clocks
        dt_n = dt_r;
        if ((state == IDLE) && start) dt_n = dt_in;
        if (ht_load)             dead_n = dt_n;
        else if (dead_r != '0)   dead_n = dead_r - 8'd1;
        else                     dead_n = '0;
        drive_ok_n = (dead_n == '0);
`else
        drive_ok_n = 1'b1;
`endif
    end

    // registered outputs derived from the state the next cycle will be in
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_p     <= 1'b0;
            tx_n     <= 1'b0;
            rx_blank <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            tx_p     <= (state_n == BURST) && !phase_n && drive_ok_n;
            tx_n     <= (state_n == BURST) &&  phase_n && drive_ok_n;
            rx_blank <= (state_n == BURST) || (state_n == BLANK);
            busy     <= (state_n != IDLE);
            done     <= (state_n == FIN);
        end
    end

endmodule

// File: tb/tb_sonar_burst_tx.sv
// tb/tb_sonar_burst_tx.sv - scoreboard bench for sonar_burst_tx
module tb_sonar_burst_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] half_period;
    logic [7:0]  num_cycles;
    logic [15:0] blank_len;
`ifdef SONAR_TX_DEADTIME_EN
    logic [7:0]  dead_time;
`endif
    logic        tx_p, tx_n, rx_blank, busy, done;

    int total = 0;
    int bad   = 0;
    logic [4:0] sb[$];

    always #5 clk = ~clk;

    sonar_burst_tx dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .half_period (half_period),
        .num_cycles  (num_cycles),
        .blank_len   (blank_len),
`ifdef SONAR_TX_DEADTIME_EN
        .dead_time   (dead_time),
`endif
        .tx_p        (tx_p),
        .tx_n        (tx_n),
        .rx_blank    (rx_blank),
        .busy        (busy),
        .done        (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s obs={p,n,blank,busy,done}=%b exp=%b", tag, obs, exp_v);
        end
    endtask

    // expected {tx_p,tx_n,rx_blank,busy,done} for cycle c after the accepted start
    function automatic logic [4:0] model(input int c, input int hp, input int nc, input int bl, input int dt);
        int b_len;
        int pos;
        logic p, n;
        b_len = 2 * nc * hp;
        if (c >= 1 && c <= b_len) begin
            pos = (c - 1) % (2 * hp);
            p = (pos < hp) && (pos >= dt);
            n = (pos >= hp) && ((pos - hp) >= dt);
            return {p, n, 1'b1, 1'b1, 1'b0};
        end else if (c >= 1 && c <= b_len + bl) begin
            return 5'b00110;
        end else if (c == b_len + bl + 1) begin
            return 5'b00011;
        end
        return 5'b00000;
    endfunction

    // one burst: push expectations, drive start, pop/compare every cycle through
    // the first idle cycle after FIN (or the cycle after an abort)
    task automatic run(input string tag, input int hp_in, input int nc, input int bl, input int dtin,
                       input int disturb_at, input int abort_at, input bit fin_start,
                       input bit abort_with_start);
        int hp, dt, f_cyc, last;
        logic [4:0] e;
        hp    = (hp_in == 0) ? 1 : hp_in;
        dt    = (dtin > hp - 1) ? hp - 1 : dtin;
        f_cyc = 2 * nc * hp + bl + 1;
        last  = (abort_at > 0) ? abort_at + 1 : f_cyc + 1;
        for (int c = 1; c <= last; c++)
            sb.push_back((abort_at > 0 && c > abort_at) ? 5'b00000 : model(c, hp, nc, bl, dt));
        half_period = 16'(hp_in);
        num_cycles  = 8'(nc);
        blank_len   = 16'(bl);
`ifdef SONAR_TX_DEADTIME_EN
        dead_time   = 8'(dtin);
`endif
        start = 1'b1;
        abort = abort_with_start;
        tick();
        start = 1'b0;
        abort = 1'b0;
        for (int c = 1; c <= last; c++) begin
            if (sb.size() == 0) begin
                check({tag, "_sb_empty"}, 5'b11111, 5'b00000);
                break;
            end
            e = sb.pop_front();
            check($sformatf("%s_c%0d", tag, c), {tx_p, tx_n, rx_blank, busy, done}, e);
            start = (c == disturb_at) || (fin_start && c == f_cyc);
            abort = (c == abort_at);
            if (c == disturb_at) begin
                half_period = 16'd9;
                num_cycles  = 8'd7;
                blank_len   = 16'd2;
            end
            if (c < last) tick();
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        half_period = '0; num_cycles = '0; blank_len = '0;
`ifdef SONAR_TX_DEADTIME_EN
        dead_time = '0;
`endif
        tick(); tick(); tick();
        check("reset", {tx_p, tx_n, rx_blank, busy, done}, 5'b00000);
        rst = 1'b0;
        tick();
        check("post_reset_idle", {tx_p, tx_n, rx_blank, busy, done}, 5'b00000);

        run("basic",       4, 3, 10, 0,  0, 0, 1'b0, 1'b0);
        run("empty",       4, 0, 0,  0,  0, 0, 1'b0, 1'b0);
        run("blank_only",  3, 0, 5,  0,  0, 0, 1'b0, 1'b1);
        run("repulse",     4, 3, 10, 0, 10, 0, 1'b1, 1'b0);
        run("backtoback",  2, 2, 0,  0,  0, 0, 1'b0, 1'b0);
        run("hp0",         0, 2, 1,  0,  0, 0, 1'b0, 1'b0);
        run("abort",       4, 3, 10, 0,  0, 6, 1'b0, 1'b0);
        tick();
        run("after_abort", 4, 3, 10, 0,  0, 0, 1'b0, 1'b0);
        run("abort_blank", 2, 1, 8,  0,  0, 7, 1'b0, 1'b0);
        tick();
`ifdef SONAR_TX_DEADTIME_EN
        run("dt2",         5, 1, 0,  2,  0, 0, 1'b0, 1'b0);
        run("dt9_clamp",   5, 1, 0,  9,  0, 0, 1'b0, 1'b0);
        run("dt1_multi",   3, 2, 2,  1,  0, 0, 1'b0, 1'b0);
`endif

        // reset in the middle of a burst: outputs clear, no done follows
        half_period = 16'd4; num_cycles = 8'd3; blank_len = 16'd10;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        check("mid_reset", {tx_p, tx_n, rx_blank, busy, done}, 5'b00000);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("mid_reset_after%0d", i), {tx_p, tx_n, rx_blank, busy, done}, 5'b00000);
        end
        run("final",       1, 1, 1,  0,  0, 0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
